// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 DIF FFT with a drain gap between stages.
// Optional bit-reversed unload port enabled by defining FFT_CTRL_BITREV_EN.
module fft_stage_ctrl #(
  parameter int FFT_N    = 1024,
  parameter int PIPE_LAT = 4,
  localparam int L       = $clog2(FFT_N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         issue_valid,
  input  logic         issue_ready,
  output logic [3:0]   stage,
  output logic [L-1:0] addr_a,
  output logic [L-1:0] addr_b,
  output logic [L-2:0] tw_addr
`ifdef FFT_CTRL_BITREV_EN
  ,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [L-1:0] out_addr
`endif
);

`ifdef FFT_CTRL_BITREV_EN
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, UNLOAD, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE} state_t;
`endif

  localparam logic [3:0] S_LAST = 4'(L - 1);
  // Counter is preloaded one short so the gap lasts max(PIPE_LAT,1) cycles.
  localparam logic [7:0] DRAIN_LOAD = (PIPE_LAT == 0) ? 8'd0 : 8'(PIPE_LAT - 1);

  state_t       state_q, state_d;
  logic [3:0]   s_q, s_d;
  logic [L-2:0] k_q, k_d;
  logic [7:0]   cnt_q, cnt_d;

  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         issue_valid_q, issue_valid_d;
  logic [3:0]   stage_q, stage_d;
  logic [L-1:0] addr_a_q, addr_a_d;
  logic [L-1:0] addr_b_q, addr_b_d;
  logic [L-2:0] tw_addr_q, tw_addr_d;

  logic [L-1:0] half_l, mask_l, k_l, j_l, a_l;

`ifdef FFT_CTRL_BITREV_EN
  logic [L-1:0] c_q, c_d;
  logic         out_valid_q, out_valid_d;
  logic [L-1:0] out_addr_q, out_addr_d;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
`ifdef FFT_CTRL_BITREV_EN
    c_d     = c_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (issue_valid_q && issue_ready) begin
          if (k_q == '1) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            k_d = k_q + (L-1)'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 8'd0) begin
          if (s_q == S_LAST) begin
`ifdef FFT_CTRL_BITREV_EN
            state_d = UNLOAD;
            c_d     = '0;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = RUN;
            s_d     = s_q + 4'd1;
            k_d     = '0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`ifdef FFT_CTRL_BITREV_EN
      UNLOAD: begin
        if (out_valid_q && out_ready) begin
          if (c_q == '1) state_d = DONE;
          else c_d = c_q + L'(1);
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered without a cycle of lag.
  always_comb begin
    half_l = L'(1) << (S_LAST - s_d);
    mask_l = half_l - L'(1);
    k_l    = {1'b0, k_d};
    j_l    = k_l & mask_l;
    a_l    = ((k_l & ~mask_l) << 1) | j_l;

    busy_d        = (state_d == RUN) || (state_d == DRAIN);
    done_d        = (state_d == DONE);
    issue_valid_d = (state_d == RUN);
    stage_d       = s_d;
    addr_a_d      = a_l;
    addr_b_d      = a_l + half_l;
    tw_addr_d     = j_l[L-2:0] << s_d;
`ifdef FFT_CTRL_BITREV_EN
    busy_d      = busy_d || (state_d == UNLOAD);
    out_valid_d = (state_d == UNLOAD);
    out_addr_d  = '0;
    for (int i = 0; i < L; i++) out_addr_d[i] = c_d[L-1-i];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      s_q           <= '0;
      k_q           <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      issue_valid_q <= 1'b0;
      stage_q       <= '0;
      addr_a_q      <= '0;
      addr_b_q      <= '0;
      tw_addr_q     <= '0;
`ifdef FFT_CTRL_BITREV_EN
      c_q           <= '0;
      out_valid_q   <= 1'b0;
      out_addr_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      k_q           <= k_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      issue_valid_q <= issue_valid_d;
      stage_q       <= stage_d;
      addr_a_q      <= addr_a_d;
      addr_b_q      <= addr_b_d;
      tw_addr_q     <= tw_addr_d;
`ifdef FFT_CTRL_BITREV_EN
      c_q           <= c_d;
      out_valid_q   <= out_valid_d;
      out_addr_q    <= out_addr_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign issue_valid = issue_valid_q;
  assign stage       = stage_q;
  assign addr_a      = addr_a_q;
  assign addr_b      = addr_b_q;
  assign tw_addr     = tw_addr_q;
`ifdef FFT_CTRL_BITREV_EN
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl: N=8/PIPE_LAT=2 ordering, backpressure and reset,
// plus an N=1024/PIPE_LAT=0 sweep, against an arithmetic reference of the butterfly order.
module tb_fft_stage_ctrl;

  localparam int N8  = 8;
  localparam int P8  = 2;
  localparam int L8  = 3;
  localparam int D8  = (P8 > 0) ? P8 : 1;
  localparam int N1K = 1024;
  localparam int P1K = 0;
  localparam int L1K = 10;
`ifdef FFT_CTRL_BITREV_EN
  localparam int UNL = 1;
`else
  localparam int UNL = 0;
`endif

  typedef struct {
    int s;
    int a;
    int b;
    int tw;
  } cmd_t;

  cmd_t exp8[$];
  cmd_t exp1k[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0, issueReady8 = 1'b1;
  logic       busy8, done8, valid8;
  logic [3:0] stage8;
  logic [2:0] a8, b8;
  logic [1:0] tw8;

  logic       start1k = 1'b0, issueReady1k = 1'b1;
  logic       busy1k, done1k, valid1k;
  logic [3:0] stage1k;
  logic [9:0] a1k, b1k;
  logic [8:0] tw1k;

`ifdef FFT_CTRL_BITREV_EN
  logic       outReady8 = 1'b1, outValid8;
  logic [2:0] outAddr8;
  logic       outReady1k = 1'b1, outValid1k;
  logic [9:0] outAddr1k;
`endif

  always #5 clk = ~clk;

  fft_stage_ctrl #(.FFT_N(N8), .PIPE_LAT(P8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
    .issue_valid(valid8), .issue_ready(issueReady8), .stage(stage8),
    .addr_a(a8), .addr_b(b8), .tw_addr(tw8)
`ifdef FFT_CTRL_BITREV_EN
    , .out_valid(outValid8), .out_ready(outReady8), .out_addr(outAddr8)
`endif
  );

  fft_stage_ctrl #(.FFT_N(N1K), .PIPE_LAT(P1K)) dut1k (
    .clk(clk), .rst(rst), .start(start1k), .busy(busy1k), .done(done1k),
    .issue_valid(valid1k), .issue_ready(issueReady1k), .stage(stage1k),
    .addr_a(a1k), .addr_b(b1k), .tw_addr(tw1k)
`ifdef FFT_CTRL_BITREV_EN
    , .out_valid(outValid1k), .out_ready(outReady1k), .out_addr(outAddr1k)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Butterfly order straight from the DIF definition: groups of 2*half, pairs half apart.
  task automatic buildRef(input int n, input bit big);
    int   l = $clog2(n);
    int   half;
    cmd_t c;
    for (int s = 0; s < l; s++) begin
      half = n >> (s + 1);
      for (int g = 0; g < n / (2 * half); g++) begin
        for (int j = 0; j < half; j++) begin
          c.s  = s;
          c.a  = 2 * g * half + j;
          c.b  = c.a + half;
          c.tw = j * (1 << s);
          if (big) exp1k.push_back(c);
          else     exp8.push_back(c);
        end
      end
    end
  endtask

  function automatic int bitRev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if (((v >> i) & 1) == 1) r += 1 << (bits - 1 - i);
    return r;
  endfunction

  // One full N=8 transform; pct is the issue_ready probability, exact adds cycle-level schedule checks.
  task automatic applyStimulus(input int pct, input bit exact, input bit poke);
    int cyc     = 0;
    int idx     = 0;
    int oidx    = 0;
    int doneCyc = -1;
    int extra   = 0;
    int expDone = L8 * (N8 / 2 + D8) + 1 + UNL * N8;
    int st;
    bit rdy;
    bit expV;
    @(negedge clk);
    start8      = 1'b1;
    issueReady8 = 1'b1;
    @(posedge clk);
    while (extra < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start8 = 1'b0;
      if (doneCyc < 0) begin
        if (valid8) begin
          if (idx < exp8.size()) begin
            checkOutput("stage", stage8, exp8[idx].s);
            checkOutput("addr_a", a8, exp8[idx].a);
            checkOutput("addr_b", b8, exp8[idx].b);
            checkOutput("tw_addr", tw8, exp8[idx].tw);
          end else begin
            checkOutput("extra_cmd", 1, 0);
          end
        end
`ifdef FFT_CTRL_BITREV_EN
        if (outValid8) checkOutput("out_addr", outAddr8, bitRev(oidx, L8));
`endif
        if (exact) begin
          expV = 1'b0;
          for (int s = 0; s < L8; s++) begin
            st = 1 + s * (N8 / 2 + D8);
            if (cyc >= st && cyc < st + N8 / 2) expV = 1'b1;
          end
          checkOutput("valid_sched", valid8, expV);
          checkOutput("done_time", done8, cyc == expDone);
        end
        checkOutput("busy", busy8, !done8);
        if (done8) doneCyc = cyc;
      end else begin
        extra++;
        checkOutput("idle_valid", valid8, 0);
        checkOutput("idle_busy", busy8, 0);
        checkOutput("idle_done", done8, 0);
      end
      rdy         = ($urandom_range(0, 99) < pct);
      issueReady8 = rdy;
`ifdef FFT_CTRL_BITREV_EN
      outReady8 = rdy;
      if (outValid8 && rdy) oidx++;
`endif
      if (valid8 && rdy) idx++;
      if (poke && (cyc == 3 || cyc == doneCyc)) start8 = 1'b1;
    end
    start8 = 1'b0;
    checkOutput("finished", doneCyc >= 0, 1);
    checkOutput("cmd_count", idx, exp8.size());
`ifdef FFT_CTRL_BITREV_EN
    checkOutput("out_count", oidx, N8);
`endif
  endtask

  initial begin
    int  cyc;
    int  idx;
    bit  seen;
    buildRef(N8, 1'b0);
    buildRef(N1K, 1'b1);

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy8, 0);
    checkOutput("rst_done", done8, 0);
    checkOutput("rst_valid", valid8, 0);
    checkOutput("rst_stage", stage8, 0);
    checkOutput("rst_addr_a", a8, 0);
    checkOutput("rst_addr_b", b8, 0);
    checkOutput("rst_tw", tw8, 0);
    checkOutput("rst_valid_1k", valid1k, 0);
`ifdef FFT_CTRL_BITREV_EN
    checkOutput("rst_out_valid", outValid8, 0);
    checkOutput("rst_out_addr", outAddr8, 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] ordering with start pokes while busy and in the done cycle");
    applyStimulus(100, 1'b1, 1'b1);
    $display("[TB] random backpressure");
    applyStimulus(50, 1'b0, 1'b0);
    applyStimulus(30, 1'b0, 1'b0);
    applyStimulus(75, 1'b0, 1'b1);

    $display("[TB] asynchronous reset in stage 1");
    @(negedge clk);
    issueReady8 = 1'b1;
    start8      = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("pre_rst_stage", stage8, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", busy8, 0);
    checkOutput("arst_valid", valid8, 0);
    checkOutput("arst_stage", stage8, 0);
    checkOutput("arst_addr_a", a8, 0);
    checkOutput("arst_addr_b", b8, 0);
    checkOutput("arst_tw", tw8, 0);
    checkOutput("arst_done", done8, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_valid", valid8, 0);
    checkOutput("post_rst_busy", busy8, 0);
    applyStimulus(100, 1'b1, 1'b0);

    $display("[TB] N=1024 PIPE_LAT=0 sweep");
    @(negedge clk);
    start1k = 1'b1;
    @(posedge clk);
    cyc  = 0;
    idx  = 0;
    seen = 1'b0;
    while (!seen && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      start1k = 1'b0;
      if (valid1k) begin
        if (idx < exp1k.size()) begin
          checkOutput("big_stage", stage1k, exp1k[idx].s);
          checkOutput("big_addr_a", a1k, exp1k[idx].a);
          checkOutput("big_addr_b", b1k, exp1k[idx].b);
          checkOutput("big_tw", tw1k, exp1k[idx].tw);
          checkOutput("big_tw_range", tw1k < 10'd512, 1);
        end else begin
          checkOutput("big_extra_cmd", 1, 0);
        end
        idx++;
      end
      if (done1k) begin
        seen = 1'b1;
        checkOutput("big_done_time", cyc, L1K * (N1K / 2 + 1) + 1 + UNL * N1K);
      end
    end
    checkOutput("big_finished", seen, 1);
    checkOutput("big_cmd_count", idx, 5120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
